// File: rtl/display_pkg.sv
// Shared constants and the hex-to-seven-segment table for the display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  // All segments off (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/test_value_display_freeze_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for the freeze button.
// rise_c pulses combinationally on the edge the accepted level goes 0->1.
module freeze_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic freeze_btn,
  output logic rise_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;

  // Accept the synchronised level once it has differed long enough.
  always_comb begin
    accept_c = (sync_q2 != level) && (cnt == CNT_LAST);
    rise_c   = accept_c && sync_q2;
  end

  // Synchronise the raw button into the clock domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= freeze_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q2 == level) begin
      cnt <= '0;
    end else if (accept_c) begin
      level <= sync_q2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/test_value_display.sv
// Four-digit multiplexed hex display of the core's test_value with a
// debounced freeze button; the shown value is captured once per frame.
module test_value_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLANK_LEADING   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [VALUE_W-1:0]    test_value,
  input  logic                  freeze_btn,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  frozen
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [REF_W-1:0]    ref_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [VALUE_W-1:0]  disp_val;
  logic                freeze_rise_c;
  logic                ref_tick_c;
  logic                frame_wrap_c;
  logic [NIBBLE_W-1:0] cur_nib_c;
  logic                lead_zero_c;
  logic                blank_c;

  freeze_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .CLK       (CLK),
    .RST       (RST),
    .freeze_btn(freeze_btn),
    .rise_c    (freeze_rise_c)
  );

  // Digit-period tick and end-of-frame detection.
  always_comb begin
    ref_tick_c   = (ref_cnt == REF_LAST);
    frame_wrap_c = ref_tick_c && (digit_idx == IDX_LAST);
  end

  // Refresh counter and digit index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_tick_c) begin
      ref_cnt   <= '0;
      digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Freeze toggles on each accepted press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frozen <= 1'b0;
    end else if (freeze_rise_c) begin
      frozen <= ~frozen;
    end
  end

  // Capture at frame boundary only, so a frame never mixes old and new nibbles;
  // a freeze landing on the same edge wins over the capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp_val <= '0;
    end else if (frame_wrap_c && !frozen && !freeze_rise_c) begin
      disp_val <= test_value;
    end
  end

  // Select the current nibble and decide whether it is a leading zero.
  always_comb begin
    cur_nib_c   = disp_val[3:0];
    lead_zero_c = 1'b0;
    case (digit_idx)
      IDX_W'(1): begin
        cur_nib_c   = disp_val[7:4];
        lead_zero_c = (disp_val[15:4] == 12'h000);
      end
      IDX_W'(2): begin
        cur_nib_c   = disp_val[11:8];
        lead_zero_c = (disp_val[15:8] == 8'h00);
      end
      IDX_W'(3): begin
        cur_nib_c   = disp_val[15:12];
        lead_zero_c = (disp_val[15:12] == 4'h0);
      end
      default: begin
        cur_nib_c   = disp_val[3:0];
        lead_zero_c = 1'b0;
      end
    endcase
    blank_c = (BLANK_LEADING != 0) && lead_zero_c;
  end

  // Output register: an/seg/dp follow the index one cycle later, together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg <= SEG_BLANK;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= blank_c ? SEG_BLANK : hex_to_seg(cur_nib_c);
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
      dp  <= ~((digit_idx == '0) && frozen);
    end
  end

endmodule
